// File: rtl/toggle_pkg.sv
// Shared types, default widths and helpers for the toggle-strobe generator.
package toggle_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Burst controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A divisor of 0 behaves like 1, so a pulse is always reachable.
    function automatic logic [31:0] div_eff(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/div_phase_counter.sv
// Phase counter: counts down the latched divisor and strobes tc_o for one
// cycle on the enabled cycle where the count reaches its terminal value.
// It reloads itself on every terminal count and on an explicit load.
module div_phase_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tc_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload_q, reload_d;

    // Terminal count is only meaningful while the counter is enabled.
    assign tc_o = en_i && (cnt_q == ONE);

    // Next count: load wins, otherwise count down and wrap to the reload value.
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load_i) begin
            cnt_d    = div_i;
            reload_d = div_i;
        end else if (en_i) begin
            if (cnt_q <= ONE) begin
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    // Counter and reload registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Toggle-strobe generator: emits one-cycle t pulses every div_eff cycles for a
// finite or continuous burst and tracks the predicted q of the downstream
// T flip-flop. state_o exposes the controller state for in-system debug.
//
// Handshake: start_i/stop_i are level requests sampled on every rising edge;
// a start is accepted only outside RUN with stop_i low, and stop_i always
// takes priority over start_i in the same cycle.
module toggle_pulse_gen
    import toggle_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             t_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pulses_sent_o,
    output logic             q_pred_o,
    output state_t           state_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic             q_pred_q, q_pred_d;
    logic             t_q, t_d;

    logic [DIV_W-1:0] div_eff_w;
    logic             accept;
    logic             finished;
    logic             cnt_en;
    logic             pulse;

    assign div_eff_w = DIV_W'(div_eff(32'(div_i)));

    // A new burst is taken only when not running and not being stopped.
    assign accept   = (state_q != RUN) && start_i && !stop_i;
    // Finite burst has emitted its last pulse; hold off further pulses.
    assign finished = (count_q != '0) && (pulses_q == count_q);
    // Pulse phase advances only in an active, unfinished, unstopped burst.
    assign cnt_en   = (state_q == RUN) && !stop_i && !finished;

    div_phase_counter #(
        .DIV_W (DIV_W)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .en_i   (cnt_en),
        .div_i  (div_eff_w),
        .tc_o   (pulse)
    );

    // Next-state logic for the burst controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (finished) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst datapath: latch on accept, count and toggle on each emitted pulse.
    always_comb begin
        count_d  = count_q;
        pulses_d = pulses_q;
        q_pred_d = q_pred_q;
        t_d      = pulse;
        if (accept) begin
            count_d  = count_i;
            pulses_d = '0;
        end else if (pulse) begin
            pulses_d = pulses_q + CNT_W'(1);
            q_pred_d = ~q_pred_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= '0;
            pulses_q <= '0;
            q_pred_q <= 1'b0;
            t_q      <= 1'b0;
        end else begin
            count_q  <= count_d;
            pulses_q <= pulses_d;
            q_pred_q <= q_pred_d;
            t_q      <= t_d;
        end
    end

    assign t_o           = t_q;
    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == DONE);
    assign pulses_sent_o = pulses_q;
    assign q_pred_o      = q_pred_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: directed bursts, an arithmetic burst model
// compared every cycle, and hand-computed checkpoints.
module tb_toggle_pulse_gen;
  import toggle_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [DW-1:0] div;
  logic [CW-1:0] count;
  logic          t;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulses_sent;
  logic          q_pred;
  state_t        dbg_state;

  int total;
  int bad;

  // model: burst described by edges since acceptance
  int m_mode;   // 0 idle, 1 run, 2 done
  int m_k;
  int m_d;
  int m_n;
  int m_t;
  int m_pulses;
  int m_q;

  toggle_pulse_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .stop_i        (stop),
    .div_i         (div),
    .count_i       (count),
    .t_o           (t),
    .busy_o        (busy),
    .done_o        (done),
    .pulses_sent_o (pulses_sent),
    .q_pred_o      (q_pred),
    .state_o       (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge right after the accepting edge
  task automatic do_start(input logic [DW-1:0] d, input logic [CW-1:0] c);
    start = 1'b1;
    div   = d;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic state_t exp_state(input int mode);
    if (mode == 1) return RUN;
    if (mode == 2) return DONE;
    return IDLE;
  endfunction

  // model update on each edge, compare shortly after
  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_t = 0; m_pulses = 0; m_q = 0; m_k = 0;
    end else begin
      m_t = 0;
      if (m_mode != 1) begin
        if (start && !stop) begin
          m_mode = 1;
          m_d = (div == 0) ? 1 : int'(div);
          m_n = int'(count);
          m_k = 0;
          m_pulses = 0;
        end
      end else if (stop) begin
        m_mode = 0;
      end else begin
        m_k++;
        if (m_n != 0 && m_k == m_n * m_d + 1) begin
          m_mode = 2;
        end else if (m_k % m_d == 0) begin
          m_t = 1;
          m_pulses = m_k / m_d;
          m_q ^= 1;
        end
      end
    end
    #1;
    check("cyc_t", 32'(t), 32'(m_t));
    check("cyc_busy", 32'(busy), 32'(m_mode == 1));
    check("cyc_done", 32'(done), 32'(m_mode == 2));
    check("cyc_pulses", 32'(pulses_sent), 32'(m_pulses % (1 << CW)));
    check("cyc_q_pred", 32'(q_pred), 32'(m_q));
    check("cyc_state", 32'(dbg_state), 32'(exp_state(m_mode)));
  end

  // directed stimulus with literal checkpoints
  initial begin
    total = 0; bad = 0;
    m_mode = 0; m_k = 0; m_d = 1; m_n = 0; m_t = 0; m_pulses = 0; m_q = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; div = '0; count = '0;

    // reset then idle
    tick(2);
    rst = 1'b1;
    tick(5);
    check("rst_t", 32'(t), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pulses", 32'(pulses_sent), 0);
    check("rst_q", 32'(q_pred), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // basic burst div=3 count=4
    do_start(8'd3, 8'd4);
    check("b_busy0", 32'(busy), 1);
    check("b_t0", 32'(t), 0);
    tick(3);
    check("b_t3", 32'(t), 1);
    check("b_p3", 32'(pulses_sent), 1);
    check("b_q3", 32'(q_pred), 1);
    tick(9);
    check("b_t12", 32'(t), 1);
    check("b_p12", 32'(pulses_sent), 4);
    check("b_busy12", 32'(busy), 1);
    tick(1);
    check("b_done13", 32'(done), 1);
    check("b_busy13", 32'(busy), 0);
    check("b_q13", 32'(q_pred), 0);

    // back-to-back in first DONE cycle: div=0 count=2
    do_start(8'd0, 8'd2);
    check("e_done_clr", 32'(done), 0);
    tick(1);
    check("e_t1", 32'(t), 1);
    tick(1);
    check("e_t2", 32'(t), 1);
    check("e_p2", 32'(pulses_sent), 2);
    tick(1);
    check("e_done3", 32'(done), 1);
    check("e_t3", 32'(t), 0);
    do_start(8'd1, 8'd1);
    tick(1);
    check("e2_t1", 32'(t), 1);
    tick(1);
    check("e2_done", 32'(done), 1);
    check("e2_q", 32'(q_pred), 1);

    // stop collision: div=4 continuous, stop in cycle ending at E8
    do_start(8'd4, 8'd0);
    tick(4);
    check("s_t4", 32'(t), 1);
    check("s_q4", 32'(q_pred), 0);
    tick(3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("s_t8", 32'(t), 0);
    check("s_busy8", 32'(busy), 0);
    check("s_done8", 32'(done), 0);
    check("s_p8", 32'(pulses_sent), 1);
    check("s_state8", 32'(dbg_state), 32'(IDLE));
    tick(3);
    check("s_t_after", 32'(t), 0);

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1; div = 8'd1; count = 8'd3;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 0);
    check("ss_state", 32'(dbg_state), 32'(IDLE));
    tick(1);

    // continuous wrap div=1
    do_start(8'd1, 8'd0);
    tick(256);
    check("w_p256", 32'(pulses_sent), 0);
    check("w_t256", 32'(t), 1);
    tick(4);
    check("w_p260", 32'(pulses_sent), 4);
    check("w_q260", 32'(q_pred), 0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("w_p_stop", 32'(pulses_sent), 4);
    check("w_t_stop", 32'(t), 0);

    // mid-burst reset div=2 count=10
    do_start(8'd2, 8'd10);
    tick(4);
    check("r_t4", 32'(t), 1);
    check("r_p4", 32'(pulses_sent), 2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("r_t5", 32'(t), 0);
    check("r_busy5", 32'(busy), 0);
    check("r_p5", 32'(pulses_sent), 0);
    check("r_q5", 32'(q_pred), 0);
    check("r_state5", 32'(dbg_state), 32'(IDLE));
    tick(1);
    check("r_t6", 32'(t), 0);
    do_start(8'd2, 8'd10);
    tick(3);
    start = 1'b1; div = 8'd7; count = 8'd1;
    tick(1);
    start = 1'b0;
    check("r2_t4", 32'(t), 1);
    check("r2_p4", 32'(pulses_sent), 2);
    tick(17);
    check("r2_done", 32'(done), 1);
    check("r2_p", 32'(pulses_sent), 10);
    check("r2_q", 32'(q_pred), 0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
